// File: rtl/solver_control.sv
// rtl/solver_control.sv - sequencer for solver_datapath: point load, z clear, microcode iteration, drain, check
// All C_* outputs are registered; each cycle they default to 0 and the active state overrides them.
module solver_control #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 8,
  parameter int NUM_LIMBS       = 3,
  parameter int SCHED_ADDR_BITS = 4,
  parameter int SCHED_LEN       = 7,
  parameter int PIPE_DEPTH      = 5,
  parameter int ITER_BITS       = 16,
  parameter int MAX_ITER        = 256
) (
  input  logic                            clock,
  input  logic                            reset,

  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LIMB_SIZE_BITS-1:0]       in_cre_limb,
  input  logic [LIMB_SIZE_BITS-1:0]       in_cim_limb,

  output logic [SCHED_ADDR_BITS-1:0]      U_addr,
  input  logic [3*LIMB_INDEX_BITS+21:0]   U_word,

  output logic                            C_cre_wr_en,
  output logic                            C_cim_wr_en,
  output logic [LIMB_SIZE_BITS-1:0]       C_cre_limb,
  output logic [LIMB_SIZE_BITS-1:0]       C_cim_limb,
  output logic [LIMB_INDEX_BITS-1:0]      C_limb_ind,
  output logic [LIMB_INDEX_BITS-1:0]      C_zre_ind,
  output logic [LIMB_INDEX_BITS-1:0]      C_zim_ind,
  output logic [1:0]                      C_zre_reg_sel,
  output logic [1:0]                      C_zim_reg_sel,
  output logic [1:0]                      C_m1_a_sel,
  output logic [1:0]                      C_m1_b_sel,
  output logic [1:0]                      C_m2_a_sel,
  output logic [1:0]                      C_m2_b_sel,
  output logic                            C_op_sel,
  output logic [1:0]                      C_zre_partial_sel,
  output logic                            C_zim_partial_sel,
  output logic [1:0]                      C_zre_acc_sel,
  output logic [1:0]                      C_zim_acc_sel,
  output logic                            C_zre_wr_en,
  output logic                            C_zim_wr_en,

  input  logic                            W_diverged,

  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ITER_BITS-1:0]            out_iter,
  output logic                            out_diverged
);

  localparam int DRAIN_BITS = $clog2(PIPE_DEPTH + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [LIMB_INDEX_BITS-1:0] LAST_LIMB  = LIMB_INDEX_BITS'(NUM_LIMBS - 1);
  localparam logic [SCHED_ADDR_BITS-1:0] LAST_ADDR  = SCHED_ADDR_BITS'(SCHED_LEN - 1);
  localparam logic [DRAIN_BITS-1:0]      LAST_DRAIN = DRAIN_BITS'(PIPE_DEPTH);
  localparam logic [ITER_BITS-1:0]       ITER_CAP   = ITER_BITS'(MAX_ITER);

  logic [2:0]                 state;
  logic [LIMB_INDEX_BITS-1:0] step_cnt;
  logic [DRAIN_BITS-1:0]      drain_cnt;
  logic [ITER_BITS-1:0]       iter_cnt;
  logic [ITER_BITS-1:0]       iter_next;
  logic                       accept;

  // Microcode word fields, MSB first
  logic [LIMB_INDEX_BITS-1:0] w_limb_ind;
  logic [LIMB_INDEX_BITS-1:0] w_zre_ind;
  logic [LIMB_INDEX_BITS-1:0] w_zim_ind;
  logic [1:0]                 w_zre_reg_sel;
  logic [1:0]                 w_zim_reg_sel;
  logic [1:0]                 w_m1_a_sel;
  logic [1:0]                 w_m1_b_sel;
  logic [1:0]                 w_m2_a_sel;
  logic [1:0]                 w_m2_b_sel;
  logic                       w_op_sel;
  logic [1:0]                 w_zre_partial_sel;
  logic                       w_zim_partial_sel;
  logic [1:0]                 w_zre_acc_sel;
  logic [1:0]                 w_zim_acc_sel;
  logic                       w_zre_wr_en;
  logic                       w_zim_wr_en;

  assign {w_limb_ind, w_zre_ind, w_zim_ind, w_zre_reg_sel, w_zim_reg_sel,
          w_m1_a_sel, w_m1_b_sel, w_m2_a_sel, w_m2_b_sel, w_op_sel,
          w_zre_partial_sel, w_zim_partial_sel, w_zre_acc_sel, w_zim_acc_sel,
          w_zre_wr_en, w_zim_wr_en} = U_word;

  assign accept    = in_valid && in_ready;
  assign iter_next = iter_cnt + ITER_BITS'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      step_cnt          <= '0;
      drain_cnt         <= '0;
      iter_cnt          <= '0;
      in_ready          <= 1'b0;
      U_addr            <= '0;
      out_valid         <= 1'b0;
      out_iter          <= '0;
      out_diverged      <= 1'b0;
      C_cre_wr_en       <= 1'b0;
      C_cim_wr_en       <= 1'b0;
      C_cre_limb        <= '0;
      C_cim_limb        <= '0;
      C_limb_ind        <= '0;
      C_zre_ind         <= '0;
      C_zim_ind         <= '0;
      C_zre_reg_sel     <= '0;
      C_zim_reg_sel     <= '0;
      C_m1_a_sel        <= '0;
      C_m1_b_sel        <= '0;
      C_m2_a_sel        <= '0;
      C_m2_b_sel        <= '0;
      C_op_sel          <= 1'b0;
      C_zre_partial_sel <= '0;
      C_zim_partial_sel <= 1'b0;
      C_zre_acc_sel     <= '0;
      C_zim_acc_sel     <= '0;
      C_zre_wr_en       <= 1'b0;
      C_zim_wr_en       <= 1'b0;
    end else begin
      C_cre_wr_en       <= 1'b0;
      C_cim_wr_en       <= 1'b0;
      C_cre_limb        <= '0;
      C_cim_limb        <= '0;
      C_limb_ind        <= '0;
      C_zre_ind         <= '0;
      C_zim_ind         <= '0;
      C_zre_reg_sel     <= '0;
      C_zim_reg_sel     <= '0;
      C_m1_a_sel        <= '0;
      C_m1_b_sel        <= '0;
      C_m2_a_sel        <= '0;
      C_m2_b_sel        <= '0;
      C_op_sel          <= 1'b0;
      C_zre_partial_sel <= '0;
      C_zim_partial_sel <= 1'b0;
      C_zre_acc_sel     <= '0;
      C_zim_acc_sel     <= '0;
      C_zre_wr_en       <= 1'b0;
      C_zim_wr_en       <= 1'b0;

      case (state)
        S_IDLE, S_LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            C_cre_wr_en <= 1'b1;
            C_cim_wr_en <= 1'b1;
            C_limb_ind  <= step_cnt;
            C_cre_limb  <= in_cre_limb;
            C_cim_limb  <= in_cim_limb;
            if (step_cnt == LAST_LIMB) begin
              step_cnt <= '0;
              in_ready <= 1'b0;
              state    <= S_CLEAR;
            end else begin
              step_cnt <= step_cnt + LIMB_INDEX_BITS'(1);
              state    <= S_LOAD;
            end
          end
        end

        // All-zero selects with write enables make the datapath store 0
        S_CLEAR: begin
          C_zre_wr_en <= 1'b1;
          C_zim_wr_en <= 1'b1;
          C_limb_ind  <= LAST_LIMB - step_cnt;
          C_zre_ind   <= LAST_LIMB - step_cnt;
          C_zim_ind   <= LAST_LIMB - step_cnt;
          if (step_cnt == LAST_LIMB) begin
            step_cnt <= '0;
            iter_cnt <= '0;
            U_addr   <= '0;
            state    <= S_ITER;
          end else begin
            step_cnt <= step_cnt + LIMB_INDEX_BITS'(1);
          end
        end

        S_ITER: begin
          C_limb_ind        <= w_limb_ind;
          C_zre_ind         <= w_zre_ind;
          C_zim_ind         <= w_zim_ind;
          C_zre_reg_sel     <= w_zre_reg_sel;
          C_zim_reg_sel     <= w_zim_reg_sel;
          C_m1_a_sel        <= w_m1_a_sel;
          C_m1_b_sel        <= w_m1_b_sel;
          C_m2_a_sel        <= w_m2_a_sel;
          C_m2_b_sel        <= w_m2_b_sel;
          C_op_sel          <= w_op_sel;
          C_zre_partial_sel <= w_zre_partial_sel;
          C_zim_partial_sel <= w_zim_partial_sel;
          C_zre_acc_sel     <= w_zre_acc_sel;
          C_zim_acc_sel     <= w_zim_acc_sel;
          C_zre_wr_en       <= w_zre_wr_en;
          C_zim_wr_en       <= w_zim_wr_en;
          if (U_addr == LAST_ADDR) begin
            U_addr    <= '0;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            U_addr <= U_addr + SCHED_ADDR_BITS'(1);
          end
        end

        // PIPE_DEPTH+1 cycles so the last word's writeback lands before W_diverged is read
        S_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            drain_cnt <= '0;
            state     <= S_CHECK;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_BITS'(1);
          end
        end

        S_CHECK: begin
          iter_cnt <= iter_next;
          if (W_diverged || (iter_next == ITER_CAP)) begin
            out_iter     <= iter_next;
            out_diverged <= W_diverged;
            out_valid    <= 1'b1;
            state        <= S_DONE;
          end else begin
            state <= S_ITER;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          U_addr    <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solver_control.sv
// tb/tb_solver_control.sv - scoreboard bench for solver_control with stub microcode ROM and datapath
module tb_solver_control;

  localparam int LIB  = 6;
  localparam int LSB  = 8;
  localparam int NL   = 3;
  localparam int SAB  = 4;
  localparam int SL   = 7;
  localparam int PD   = 5;
  localparam int IB   = 16;
  localparam int MAXI = 4;
  localparam int WB   = 3*LIB + 22;
  localparam int CB   = 2 + 2*LSB + WB;

  logic            clock;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [LSB-1:0]  in_cre_limb;
  logic [LSB-1:0]  in_cim_limb;
  logic [SAB-1:0]  U_addr;
  logic [WB-1:0]   U_word;
  logic            C_cre_wr_en, C_cim_wr_en;
  logic [LSB-1:0]  C_cre_limb, C_cim_limb;
  logic [LIB-1:0]  C_limb_ind, C_zre_ind, C_zim_ind;
  logic [1:0]      C_zre_reg_sel, C_zim_reg_sel, C_m1_a_sel, C_m1_b_sel, C_m2_a_sel, C_m2_b_sel;
  logic            C_op_sel;
  logic [1:0]      C_zre_partial_sel;
  logic            C_zim_partial_sel;
  logic [1:0]      C_zre_acc_sel, C_zim_acc_sel;
  logic            C_zre_wr_en, C_zim_wr_en;
  logic            W_diverged;
  logic            out_valid;
  logic            out_ready;
  logic [IB-1:0]   out_iter;
  logic            out_diverged;

  solver_control #(
    .LIMB_INDEX_BITS(LIB), .LIMB_SIZE_BITS(LSB), .NUM_LIMBS(NL), .SCHED_ADDR_BITS(SAB),
    .SCHED_LEN(SL), .PIPE_DEPTH(PD), .ITER_BITS(IB), .MAX_ITER(MAXI)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cre_limb(in_cre_limb), .in_cim_limb(in_cim_limb),
    .U_addr(U_addr), .U_word(U_word),
    .C_cre_wr_en(C_cre_wr_en), .C_cim_wr_en(C_cim_wr_en), .C_cre_limb(C_cre_limb), .C_cim_limb(C_cim_limb),
    .C_limb_ind(C_limb_ind), .C_zre_ind(C_zre_ind), .C_zim_ind(C_zim_ind),
    .C_zre_reg_sel(C_zre_reg_sel), .C_zim_reg_sel(C_zim_reg_sel),
    .C_m1_a_sel(C_m1_a_sel), .C_m1_b_sel(C_m1_b_sel), .C_m2_a_sel(C_m2_a_sel), .C_m2_b_sel(C_m2_b_sel),
    .C_op_sel(C_op_sel), .C_zre_partial_sel(C_zre_partial_sel), .C_zim_partial_sel(C_zim_partial_sel),
    .C_zre_acc_sel(C_zre_acc_sel), .C_zim_acc_sel(C_zim_acc_sel),
    .C_zre_wr_en(C_zre_wr_en), .C_zim_wr_en(C_zim_wr_en),
    .W_diverged(W_diverged),
    .out_valid(out_valid), .out_ready(out_ready), .out_iter(out_iter), .out_diverged(out_diverged)
  );

  typedef struct {
    bit            is_res;
    logic [CB-1:0] bundle;
    int            addr;
    int            gap;
    int            iter;
    bit            div;
  } exp_t;

  exp_t          sb[$];
  logic [WB-1:0] rom [0:15];
  logic [LSB-1:0] cre [0:NL-1];
  logic [LSB-1:0] cim [0:NL-1];
  int            n_cmp, n_fail, cyc, last_evt, prev_addr, div_iter, iters_seen;
  bit            mon_en;
  logic          prev_ov;
  logic [CB-1:0] mon_bus;
  exp_t          mon_e;

  assign U_word = rom[U_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [CB-1:0] c_bus();
    return {C_cre_wr_en, C_cim_wr_en, C_cre_limb, C_cim_limb, C_limb_ind, C_zre_ind, C_zim_ind,
            C_zre_reg_sel, C_zim_reg_sel, C_m1_a_sel, C_m1_b_sel, C_m2_a_sel, C_m2_b_sel,
            C_op_sel, C_zre_partial_sel, C_zim_partial_sel, C_zre_acc_sel, C_zim_acc_sel,
            C_zre_wr_en, C_zim_wr_en};
  endfunction

  function automatic void push_c(logic [CB-1:0] b, int addr, int gap);
    exp_t e;
    e.is_res = 1'b0; e.bundle = b; e.addr = addr; e.gap = gap; e.iter = 0; e.div = 1'b0;
    sb.push_back(e);
  endfunction

  function automatic void push_res(int iter, bit div, int gap);
    exp_t e;
    e.is_res = 1'b1; e.bundle = '0; e.addr = -1; e.gap = gap; e.iter = iter; e.div = div;
    sb.push_back(e);
  endfunction

  task automatic check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic abort(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  // Monitor: every non-zero C_* cycle and every rising out_valid pops one scoreboard entry
  always @(negedge clock) begin
    if (mon_en && reset) begin
      mon_bus = c_bus();
      if (mon_bus != '0) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL c_event: got bus=%h, scoreboard empty", mon_bus);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.is_res || mon_e.bundle != mon_bus ||
              (mon_e.addr >= 0 && mon_e.addr != prev_addr) ||
              (mon_e.gap >= 0 && mon_e.gap != cyc - last_evt)) begin
            n_fail++;
            $display("FAIL c_event: got bus=%h prev_addr=%0d gap=%0d, want result=%0d bus=%h addr=%0d gap=%0d",
                     mon_bus, prev_addr, cyc - last_evt, mon_e.is_res, mon_e.bundle, mon_e.addr, mon_e.gap);
          end
        end
        last_evt = cyc;
      end
      if (out_valid && !prev_ov) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL result: got iter=%0d div=%0b, scoreboard empty", out_iter, out_diverged);
        end else begin
          mon_e = sb.pop_front();
          if (!mon_e.is_res || int'(out_iter) != mon_e.iter || out_diverged != mon_e.div ||
              mon_e.gap != cyc - last_evt) begin
            n_fail++;
            $display("FAIL result: got iter=%0d div=%0b gap=%0d, want result=%0d iter=%0d div=%0b gap=%0d",
                     out_iter, out_diverged, cyc - last_evt, mon_e.is_res, mon_e.iter, mon_e.div, mon_e.gap);
          end
        end
        last_evt = cyc;
      end
    end
    prev_ov   = out_valid;
    prev_addr = int'(U_addr);
  end

  // Datapath stub: diverges from the end of iteration div_iter onward; noise while only ITER can be active
  always @(negedge clock) begin
    if (reset && int'(U_addr) == SL - 1) iters_seen++;
    if (div_iter != 0 && iters_seen >= div_iter) W_diverged = 1'b1;
    else if (U_addr != '0)                       W_diverged = 1'($urandom_range(0, 1));
    else                                         W_diverged = 1'b0;
  end

  task automatic new_rom();
    logic [WB-1:0] w;
    for (int a = 0; a < 16; a++) begin
      do w = {8'($urandom), $urandom}; while (w == '0);
      rom[a] = w;
    end
  endtask

  task automatic send_beats();
    int tmo;
    for (int b = 0; b < NL; b++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clock);
      end
      tmo = 0;
      while (!in_ready && tmo < 50) begin
        @(negedge clock);
        tmo++;
      end
      if (!in_ready) abort("in_ready_wait");
      in_valid    = 1'b1;
      in_cre_limb = cre[b];
      in_cim_limb = cim[b];
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic run_point(input int div, input int stall, input bit fixed);
    int n, tmo;
    bit dv;
    logic [LIB-1:0] ind;
    new_rom();
    for (int b = 0; b < NL; b++) begin
      cre[b] = fixed ? ((b == 1) ? 8'h80 : 8'h00) : 8'($urandom);
      cim[b] = fixed ? ((b == 0) ? 8'hfe : (b == 1) ? 8'h80 : 8'h00) : 8'($urandom);
    end
    dv = (div != 0) && (div <= MAXI);
    n  = dv ? div : MAXI;
    for (int b = 0; b < NL; b++) begin
      ind = LIB'(b);
      push_c({1'b1, 1'b1, cre[b], cim[b], ind, {(WB-LIB){1'b0}}}, 0, -1);
    end
    for (int j = 0; j < NL; j++) begin
      ind = LIB'(NL - 1 - j);
      push_c({{(2+2*LSB){1'b0}}, ind, ind, ind, 20'b0, 1'b1, 1'b1}, 0, 1);
    end
    for (int it = 0; it < n; it++)
      for (int a = 0; a < SL; a++)
        push_c({{(2+2*LSB){1'b0}}, rom[a]}, a, (a == 0 && it > 0) ? (SL + PD + 2 - (SL - 1)) : 1);
    push_res(n, dv, PD + 2);

    iters_seen = 0;
    div_iter   = div;
    send_beats();

    tmo = 0;
    while (!out_valid && tmo < 3000) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_cre_limb = 8'($urandom);
      in_cim_limb = 8'($urandom);
      @(negedge clock);
      tmo++;
    end
    in_valid = 1'b0;
    if (!out_valid) abort("out_valid_wait");

    for (int s = 0; s < stall; s++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_out_iter", out_iter, n);
      check("hold_out_div", out_diverged, dv);
      check("hold_in_ready", in_ready, 0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("post_xfer_out_valid", out_valid, 0);
    check("post_xfer_in_ready", in_ready, 1);
  endtask

  initial begin
    int tmo;
    n_cmp = 0; n_fail = 0; cyc = 0; last_evt = 0; prev_addr = 0;
    div_iter = 0; iters_seen = 0; mon_en = 1'b0;
    reset = 1'b0; in_valid = 1'b0; in_cre_limb = '0; in_cim_limb = '0; out_ready = 1'b0;
    new_rom();
    repeat (3) @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_U_addr", U_addr, 0);
    check("rst_c_bus", c_bus(), 0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_in_ready", in_ready, 1);
    mon_en = 1'b1;

    run_point(3, 0, 1'b1);
    run_point(0, 0, 1'b0);
    run_point(int'($urandom_range(0, MAXI + 2)), 10, 1'b0);
    for (int p = 0; p < 6; p++)
      run_point(int'($urandom_range(0, MAXI + 2)), int'($urandom_range(0, 3)), 1'b0);

    // Reset between clock edges in the middle of an iteration
    mon_en = 1'b0;
    new_rom();
    for (int b = 0; b < NL; b++) begin
      cre[b] = 8'($urandom);
      cim[b] = 8'($urandom);
    end
    iters_seen = 0;
    div_iter   = 0;
    send_beats();
    tmo = 0;
    while (int'(U_addr) != 3 && tmo < 200) begin
      @(negedge clock);
      tmo++;
    end
    if (int'(U_addr) != 3) abort("mid_iter_wait");
    #2 reset = 1'b0;
    #1;
    check("async_U_addr", U_addr, 0);
    check("async_c_bus", c_bus(), 0);
    check("async_in_ready", in_ready, 0);
    check("async_out_valid", out_valid, 0);
    check("async_out_iter", out_iter, 0);
    check("async_out_div", out_diverged, 0);
    sb.delete();
    @(negedge clock);
    @(negedge clock);
    iters_seen = 0;
    reset = 1'b1;
    @(negedge clock);
    check("rerst_in_ready", in_ready, 1);
    mon_en = 1'b1;
    run_point(2, 1, 1'b0);

    repeat (5) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
